// File: rtl/irq_pending_latch_pkg.sv
// Shared definitions for the interrupt pending latch: line count,
// acknowledge code constants and the code-to-line mapping.
package irq_pending_latch_pkg;

    localparam int NLINES = 4;

    // Acknowledge codes, MSB-first: line0 is the all-ones code.
    localparam logic [1:0] CODE_L0 = 2'b11;
    localparam logic [1:0] CODE_L1 = 2'b10;
    localparam logic [1:0] CODE_L2 = 2'b01;
    localparam logic [1:0] CODE_L3 = 2'b00;

    // Map an acknowledge code onto the line index it addresses.
    function automatic logic [1:0] code_to_idx(input logic [1:0] code);
        case (code)
            CODE_L0: return 2'd0;
            CODE_L1: return 2'd1;
            CODE_L2: return 2'd2;
            default: return 2'd3;
        endcase
    endfunction

endpackage

// File: rtl/irq_pending_latch_line.sv
// One request line: pending bit, sticky overflow flag and masked,
// registered output. A set event beats a coincident acknowledge.
module irq_line_cell (
    input  logic clk,
    input  logic rst_n,
    input  logic evt,
    input  logic clr,
    input  logic mask,
    output logic d,
    output logic ovf
);

    logic pend_q, pend_d;
    logic ovf_q, ovf_d;
    logic d_q, d_d;

    // Next-state: set wins over clear; overflow only on an unacked re-hit.
    always_comb begin
        pend_d = pend_q;
        ovf_d  = ovf_q;
        if (evt) begin
            pend_d = 1'b1;
            if (pend_q && !clr) begin
                ovf_d = 1'b1;
            end
        end else if (clr) begin
            pend_d = 1'b0;
        end
        d_d = pend_d & mask;
    end

    // Line state registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pend_q <= 1'b0;
            ovf_q  <= 1'b0;
            d_q    <= 1'b0;
        end else begin
            pend_q <= pend_d;
            ovf_q  <= ovf_d;
            d_q    <= d_d;
        end
    end

    assign d   = d_q;
    assign ovf = ovf_q;

endmodule

// File: rtl/irq_pending_latch.sv
// Interrupt pending latch: captures request edges (or levels) per line,
// holds them until acknowledged and forwards pending & mask downstream.
// Optional macro IRQ_SYNC_EN inserts a 2-flop input synchronizer.
module irq_pending_latch
    import irq_pending_latch_pkg::*;
#(
    parameter int LEVEL = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [0:NLINES-1] req,
    input  logic [0:NLINES-1] mask,
    input  logic              ack,
    input  logic [0:1]        ack_code,
    output logic [0:NLINES-1] D,
    output logic              any,
    output logic [0:NLINES-1] ovf
);

    logic [0:NLINES-1] det_in;
    logic              det_ok;
    logic [0:NLINES-1] req_q, req_d;
    logic [0:NLINES-1] evt;
    logic [0:NLINES-1] clr;
    logic [0:NLINES-1] d;

`ifdef IRQ_SYNC_EN
    // The synchronizer restarts from zero on reset; warm_q blanks detection
    // until it has refilled so a line held high through reset stays quiet.
    logic [0:NLINES-1] sync1_q, sync1_d;
    logic [0:NLINES-1] sync2_q, sync2_d;
    logic [1:0]        warm_q, warm_d;

    // Synchronizer and warm-up shift next-state.
    always_comb begin
        sync1_d = req;
        sync2_d = sync1_q;
        warm_d  = {warm_q[0], 1'b1};
    end

    // Synchronizer registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync1_q <= '0;
            sync2_q <= '0;
            warm_q  <= '0;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            warm_q  <= warm_d;
        end
    end

    assign det_in = sync2_q;
    assign det_ok = warm_q[1];
`else
    assign det_in = req;
    assign det_ok = 1'b1;
`endif

    // Edge/level detection against the previous sample.
    always_comb begin
        req_d = det_ok ? det_in : req_q;
        evt   = '0;
        for (int i = 0; i < NLINES; i++) begin
            if (LEVEL != 0) begin
                evt[i] = det_ok & det_in[i];
            end else begin
                evt[i] = det_ok & det_in[i] & ~req_q[i];
            end
        end
    end

    // Previous-sample register; loads the live input during reset so that
    // a line already high at release is not seen as a new edge.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            req_q <= req;
        end else begin
            req_q <= req_d;
        end
    end

    // One-hot clear from the acknowledge strobe.
    always_comb begin
        clr = '0;
        if (ack) begin
            clr[code_to_idx(ack_code)] = 1'b1;
        end
    end

    for (genvar g = 0; g < NLINES; g++) begin : g_line
        irq_line_cell u_cell (
            .clk   (clk),
            .rst_n (rst_n),
            .evt   (evt[g]),
            .clr   (clr[g]),
            .mask  (mask[g]),
            .d     (d[g]),
            .ovf   (ovf[g])
        );
    end

    assign D   = d;
    assign any = |d;

endmodule

// File: tb/tb_irq_pending_latch.sv
module tb_irq_pending_latch;

`ifdef IRQ_SYNC_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 0;
`endif

    logic       clk = 1'b0;
    logic       rst_n;
    logic [0:3] req;
    logic [0:3] mask;
    logic       ack;
    logic [0:1] ack_code;
    logic [0:3] d_o;
    logic       any_o;
    logic [0:3] ovf_o;

    int n_checks = 0;
    int n_err    = 0;

    irq_pending_latch #(.LEVEL(0)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .req      (req),
        .mask     (mask),
        .ack      (ack),
        .ack_code (ack_code),
        .D        (d_o),
        .any      (any_o),
        .ovf      (ovf_o)
    );

    always #5 clk = ~clk;

    // Behavioural reference: what each line has seen, pending and overflow.
    bit [0:3]   m_pend, m_ovf, m_d, m_prev;
    logic [0:3] hist[$];

    task automatic model_step();
        bit [0:3] seen;
        bit [0:3] evt;
        bit       valid;
        bit       hit;
        int       ai;
        if (!rst_n) begin
            m_pend = '0;
            m_ovf  = '0;
            m_d    = '0;
            m_prev = req;
            hist.delete();
        end else begin
            hist.push_back(req);
            valid = hist.size() > LAT;
            seen  = valid ? hist[hist.size() - 1 - LAT] : 4'b0000;
            evt   = '0;
            if (valid) begin
                for (int i = 0; i < 4; i++) evt[i] = seen[i] && !m_prev[i];
                m_prev = seen;
            end
            ai = 3 - int'(ack_code);
            for (int i = 0; i < 4; i++) begin
                hit = ack && (ai == i);
                if (evt[i] && m_pend[i] && !hit) m_ovf[i] = 1'b1;
                if (evt[i]) m_pend[i] = 1'b1;
                else if (hit) m_pend[i] = 1'b0;
            end
            m_d = m_pend & mask;
            if (hist.size() > 3) void'(hist.pop_front());
        end
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [3:0] act, input logic [3:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %b expected %b", nm, act, exp);
        end
    endtask

    task automatic chk_model(input string tag);
        chk({tag, " D"}, d_o, m_d);
        chk({tag, " ovf"}, ovf_o, m_ovf);
        chk({tag, " any"}, {3'b000, any_o}, {3'b000, |m_d});
    endtask

    typedef struct {
        logic       rst;
        logic [0:3] req;
        logic [0:3] mask;
        logic       ack;
        logic [0:1] code;
        logic [0:3] exp_d;
        logic [0:3] exp_ovf;
    } vec_t;

    function automatic vec_t v(logic rs, logic [0:3] rq, logic [0:3] mk, logic ak,
                               logic [0:1] cd, logic [0:3] ed, logic [0:3] eo);
        vec_t t;
        t.rst = rs; t.req = rq; t.mask = mk; t.ack = ak; t.code = cd;
        t.exp_d = ed; t.exp_ovf = eo;
        return t;
    endfunction

    vec_t vec[25];

    initial begin
        vec[0]  = v(1, 4'b0001, 4'b1111, 0, 2'b00, 4'b0001, 4'b0000);
        vec[1]  = v(1, 4'b0001, 4'b1111, 1, 2'b00, 4'b0000, 4'b0000);
        vec[2]  = v(1, 4'b0000, 4'b1111, 0, 2'b00, 4'b0000, 4'b0000);
        vec[3]  = v(1, 4'b1010, 4'b1111, 0, 2'b00, 4'b1010, 4'b0000);
        vec[4]  = v(1, 4'b1010, 4'b1111, 1, 2'b11, 4'b0010, 4'b0000);
        vec[5]  = v(1, 4'b0000, 4'b1111, 1, 2'b01, 4'b0000, 4'b0000);
        vec[6]  = v(1, 4'b1000, 4'b1111, 0, 2'b00, 4'b1000, 4'b0000);
        vec[7]  = v(1, 4'b0000, 4'b1111, 0, 2'b00, 4'b1000, 4'b0000);
        vec[8]  = v(1, 4'b1000, 4'b1111, 0, 2'b00, 4'b1000, 4'b1000);
        vec[9]  = v(1, 4'b0000, 4'b1111, 1, 2'b11, 4'b0000, 4'b1000);
        vec[10] = v(1, 4'b0010, 4'b1111, 0, 2'b00, 4'b0010, 4'b1000);
        vec[11] = v(1, 4'b0000, 4'b1111, 0, 2'b00, 4'b0010, 4'b1000);
        vec[12] = v(1, 4'b0010, 4'b1111, 1, 2'b01, 4'b0010, 4'b1000);
        vec[13] = v(1, 4'b0000, 4'b1111, 1, 2'b01, 4'b0000, 4'b1000);
        vec[14] = v(1, 4'b0000, 4'b1111, 1, 2'b10, 4'b0000, 4'b1000);
        vec[15] = v(1, 4'b0100, 4'b0000, 0, 2'b00, 4'b0000, 4'b1000);
        vec[16] = v(1, 4'b0100, 4'b0100, 0, 2'b00, 4'b0100, 4'b1000);
        vec[17] = v(1, 4'b0000, 4'b1111, 1, 2'b10, 4'b0000, 4'b1000);
        vec[18] = v(1, 4'b1111, 4'b1011, 0, 2'b00, 4'b1011, 4'b1000);
        vec[19] = v(1, 4'b0000, 4'b1111, 0, 2'b00, 4'b1111, 4'b1000);
        vec[20] = v(0, 4'b0000, 4'b1111, 0, 2'b00, 4'b0000, 4'b0000);
        vec[21] = v(1, 4'b0001, 4'b1111, 0, 2'b00, 4'b0001, 4'b0000);
        vec[22] = v(0, 4'b0001, 4'b1111, 0, 2'b00, 4'b0000, 4'b0000);
        vec[23] = v(1, 4'b0001, 4'b1111, 0, 2'b00, 4'b0000, 4'b0000);
        vec[24] = v(1, 4'b0001, 4'b1111, 0, 2'b00, 4'b0000, 4'b0000);

        rst_n = 1'b0; req = '0; mask = 4'b1111; ack = 1'b0; ack_code = 2'b00;
        tick();
        tick();
        chk("reset D", d_o, 4'b0000);
        chk("reset ovf", ovf_o, 4'b0000);
        chk("reset any", {3'b000, any_o}, 4'b0000);
        chk_model("reset model");

`ifndef IRQ_SYNC_EN
        for (int r = 0; r < 25; r++) begin
            rst_n = vec[r].rst; req = vec[r].req; mask = vec[r].mask;
            ack = vec[r].ack; ack_code = vec[r].code;
            tick();
            chk($sformatf("row%0d D", r), d_o, vec[r].exp_d);
            chk($sformatf("row%0d ovf", r), ovf_o, vec[r].exp_ovf);
            chk($sformatf("row%0d any", r), {3'b000, any_o}, {3'b000, |vec[r].exp_d});
            chk_model($sformatf("row%0d model", r));
        end
`else
        rst_n = 1'b0; req = '0; mask = 4'b1111; ack = 1'b0;
        tick();
        rst_n = 1'b1; req = 4'b0001;
        tick();
        chk("sync lat1 D", d_o, 4'b0000);
        tick();
        chk("sync lat2 D", d_o, 4'b0000);
        tick();
        chk("sync lat3 D", d_o, 4'b0001);
        chk_model("sync lat model");
        rst_n = 1'b0; req = 4'b1111;
        tick();
        tick();
        rst_n = 1'b1;
        for (int c = 0; c < 6; c++) begin
            tick();
            chk($sformatf("sync held c%0d D", c), d_o, 4'b0000);
            chk($sformatf("sync held c%0d ovf", c), ovf_o, 4'b0000);
            chk_model($sformatf("sync held c%0d model", c));
        end
`endif

        ack = 1'b0;
        for (int c = 0; c < 400; c++) begin
            rst_n    = ($urandom_range(0, 39) != 0);
            req      = 4'($urandom);
            mask     = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'b1111;
            ack      = ($urandom_range(0, 2) == 0);
            ack_code = 2'($urandom);
            tick();
            chk_model($sformatf("rand%0d", c));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
